// File: rtl/led_string_serializer.sv
// Single-wire NRZ encoder for one addressable LED string: double-buffered
// 24-bit pixels shifted MSB-first as fixed-period pulses, plus frame latch.
module led_string_serializer #(
    parameter int BITS_PER_PIXEL = 24,
    parameter int T_BIT          = 25,
    parameter int T0H            = 8,
    parameter int T1H            = 16,
    parameter int T_LATCH        = 1200
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [BITS_PER_PIXEL-1:0] pixel_data,
    input  logic                      pixel_valid,
    output logic                      pixel_ready,
    input  logic                      frame_end,
    output logic                      busy,
    output logic                      underrun,
    output logic                      led_sdi
);

    localparam int PW = $clog2(T_BIT);
    localparam int BW = $clog2(BITS_PER_PIXEL);
    localparam int LW = $clog2(T_LATCH + 1);

    localparam logic [PW-1:0] PH_LAST = PW'(T_BIT - 1);
    localparam logic [PW-1:0] TH_ONE  = PW'(T1H);
    localparam logic [PW-1:0] TH_ZERO = PW'(T0H);
    localparam logic [BW-1:0] BN_LAST = BW'(BITS_PER_PIXEL - 1);
    localparam logic [LW-1:0] LC_LAST = LW'(T_LATCH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        LATCH
    } state_t;

    state_t                    state, state_d;
    logic [BITS_PER_PIXEL-1:0] hold, hold_d;
    logic [BITS_PER_PIXEL-1:0] shift, shift_d;
    logic                      hold_full, hold_full_d;
    logic                      fe_pend, fe_pend_d;
    logic [PW-1:0]             phase, phase_d;
    logic [BW-1:0]             bitn, bitn_d;
    logic [LW-1:0]             lcnt, lcnt_d;
    logic                      led_d;
    logic                      underrun_d;
    logic                      fe_consume;
    logic [PW-1:0]             thr;

    assign pixel_ready = !hold_full;
    assign busy        = (state != IDLE) || hold_full;
    assign thr         = shift[BITS_PER_PIXEL-1] ? TH_ONE : TH_ZERO;

    always_comb begin
        state_d     = state;
        hold_d      = hold;
        shift_d     = shift;
        hold_full_d = hold_full;
        phase_d     = phase;
        bitn_d      = bitn;
        lcnt_d      = lcnt;
        led_d       = 1'b0;
        underrun_d  = 1'b0;
        fe_consume  = 1'b0;

        // Transfer and hold consumption are mutually exclusive (ready = !hold_full).
        if (pixel_valid && !hold_full) begin
            hold_d      = pixel_data;
            hold_full_d = 1'b1;
        end

        case (state)
            IDLE: begin
                if (hold_full) begin
                    shift_d     = hold;
                    hold_full_d = 1'b0;
                    phase_d     = '0;
                    bitn_d      = '0;
                    state_d     = SEND;
                end else if (fe_pend) begin
                    fe_consume = 1'b1;
                    lcnt_d     = '0;
                    state_d    = LATCH;
                end
            end
            SEND: begin
                led_d = (phase < thr);
                if (phase == PH_LAST) begin
                    phase_d = '0;
                    shift_d = {shift[BITS_PER_PIXEL-2:0], 1'b0};
                    bitn_d  = bitn + 1'b1;
                    if (bitn == BN_LAST) begin
                        bitn_d = '0;
                        if (hold_full) begin
                            shift_d     = hold;
                            hold_full_d = 1'b0;
                        end else if (fe_pend) begin
                            fe_consume = 1'b1;
                            lcnt_d     = '0;
                            state_d    = LATCH;
                        end else begin
                            underrun_d = 1'b1;
                            state_d    = IDLE;
                        end
                    end
                end else begin
                    phase_d = phase + 1'b1;
                end
            end
            LATCH: begin
                if (lcnt == LC_LAST) begin
                    state_d = IDLE;
                end else begin
                    lcnt_d = lcnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A frame_end arriving on the very cycle the pending one is consumed is absorbed.
        fe_pend_d = fe_pend;
        if (fe_consume) begin
            fe_pend_d = 1'b0;
        end else if (frame_end && (state != LATCH)) begin
            fe_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            hold      <= '0;
            shift     <= '0;
            hold_full <= 1'b0;
            fe_pend   <= 1'b0;
            phase     <= '0;
            bitn      <= '0;
            lcnt      <= '0;
            led_sdi   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_d;
            hold      <= hold_d;
            shift     <= shift_d;
            hold_full <= hold_full_d;
            fe_pend   <= fe_pend_d;
            phase     <= phase_d;
            bitn      <= bitn_d;
            lcnt      <= lcnt_d;
            led_sdi   <= led_d;
            underrun  <= underrun_d;
        end
    end

endmodule

// File: tb/tb_led_string_serializer.sv
// Directed self-checking bench for led_string_serializer: line waveform is
// logged per cycle and compared against hand-derived pulse timing.
module tb_led_string_serializer;

    localparam int LOGN = 16384;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        frame_end;
    logic        busy;
    logic        underrun;
    logic        led_sdi;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int ur_cnt   = 0;
    int ur_cyc   = -1;

    logic line_log  [0:LOGN-1];
    logic busy_log  [0:LOGN-1];
    logic ready_log [0:LOGN-1];

    logic [23:0] words [0:3];
    int          acc   [0:3];

    led_string_serializer #(
        .BITS_PER_PIXEL(24),
        .T_BIT(25),
        .T0H(8),
        .T1H(16),
        .T_LATCH(1200)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pixel_data(pixel_data),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .frame_end(frame_end),
        .busy(busy),
        .underrun(underrun),
        .led_sdi(led_sdi)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sampled mid-cycle: entry [k] holds outputs as registered at edge k.
    always @(negedge clk) begin
        if (cyc < LOGN) begin
            line_log[cyc]  = led_sdi;
            busy_log[cyc]  = busy;
            ready_log[cyc] = pixel_ready;
        end
        if (underrun === 1'b1) begin
            ur_cnt = ur_cnt + 1;
            ur_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic count_high(input int a, input int b, output int n);
        n = 0;
        for (int i = a; i <= b; i++)
            if (i >= 0 && i < LOGN && line_log[i] === 1'b1) n++;
    endtask

    task automatic count_busy(input int a, input int b, output int n);
        n = 0;
        for (int i = a; i <= b; i++)
            if (i >= 0 && i < LOGN && busy_log[i] === 1'b1) n++;
    endtask

    task automatic count_ready(input int a, input int b, output int n);
        n = 0;
        for (int i = a; i <= b; i++)
            if (i >= 0 && i < LOGN && ready_log[i] === 1'b1) n++;
    endtask

    // Expected cell: bit from MSB, high for 16 (one) or 8 (zero) of 25 cycles.
    task automatic check_pixel(input string tag, input int start, input logic [23:0] word);
        int   errs;
        int   bi;
        logic b;
        logic e;
        errs = 0;
        for (int t = 0; t < 600; t++) begin
            bi = 23 - t / 25;
            b  = word[bi];
            e  = ((t % 25) < (b ? 16 : 8));
            if (start + t >= LOGN || line_log[start + t] !== e) errs++;
        end
        check(tag, errs, 0);
    endtask

    task automatic send_one(input logic [23:0] d, input logic fe, output int a);
        int c;
        for (c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (pixel_ready) break;
        end
        if (c == 2000) check("ready_timeout", 0, 1);
        pixel_data  = d;
        pixel_valid = 1'b1;
        frame_end   = fe;
        @(negedge clk);
        a           = cyc;
        pixel_valid = 1'b0;
        frame_end   = 1'b0;
    endtask

    // Streams words[0..n-1] with valid held high; frame_end rides with the last word.
    task automatic stream(input int n, input logic fe);
        int   k;
        logic pend;
        k           = 0;
        @(negedge clk);
        pixel_data  = words[0];
        pixel_valid = 1'b1;
        frame_end   = fe && (n == 1);
        pend        = pixel_ready;
        for (int c = 0; c < 5000 && k < n; c++) begin
            @(negedge clk);
            if (pend) begin
                acc[k] = cyc;
                k++;
                if (k < n) begin
                    pixel_data = words[k];
                    frame_end  = fe && (k == n - 1);
                end else begin
                    pixel_valid = 1'b0;
                    frame_end   = 1'b0;
                end
            end
            pend = pixel_valid && pixel_ready;
        end
        pixel_valid = 1'b0;
        frame_end   = 1'b0;
        check("stream_accepted", k, n);
    endtask

    initial begin
        int n;
        int base_ur;
        int a0;
        int a1;
        int s;
        int e;
        int f;
        int r;

        reset       = 1'b1;
        pixel_data  = '0;
        pixel_valid = 1'b0;
        frame_end   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_led", led_sdi, 0);
        check("rst_ready", pixel_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_underrun", underrun, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single pixel with frame_end in the same cycle
        base_ur = ur_cnt;
        send_one(24'hA500FF, 1'b1, a0);
        wait_until(a0 + 1810);
        check("sp_pre_high", line_log[a0 + 1], 0);
        check("sp_first_high", line_log[a0 + 2], 1);
        check_pixel("sp_pattern", a0 + 2, 24'hA500FF);
        count_high(a0 + 602, a0 + 1801, n);
        check("sp_latch_low", n, 0);
        check("sp_latch_busy_end", busy_log[a0 + 1800], 1);
        check("sp_idle_after_latch", busy_log[a0 + 1801], 0);
        check("sp_no_underrun", ur_cnt - base_ur, 0);

        // Back-to-back four pixels
        base_ur  = ur_cnt;
        words[0] = 24'hF0F0F0;
        words[1] = 24'h0F0F0F;
        words[2] = 24'h123456;
        words[3] = 24'hFEDCBA;
        stream(4, 1'b1);
        s = acc[0] + 2;
        e = s + 2400;
        wait_until(e + 1210);
        check("b2b_acc1", acc[1] - acc[0], 2);
        check("b2b_acc2", acc[2] - acc[0], 602);
        check("b2b_acc3", acc[3] - acc[0], 1202);
        for (int i = 0; i < 4; i++) check_pixel("b2b_pattern", s + 600 * i, words[i]);
        count_ready(acc[0] - 1, acc[3] - 1, n);
        check("b2b_ready_pulses", n, 4);
        count_high(e, e + 1199, n);
        check("b2b_latch_low", n, 0);
        check("b2b_no_underrun", ur_cnt - base_ur, 0);

        // Underrun: single pixel, no frame_end
        base_ur = ur_cnt;
        send_one(24'h800001, 1'b0, a0);
        wait_until(a0 + 650);
        check_pixel("ur_pattern", a0 + 2, 24'h800001);
        check("ur_count", ur_cnt - base_ur, 1);
        check("ur_time", ur_cyc - a0, 601);
        check("ur_busy_before", busy_log[a0 + 600], 1);
        check("ur_busy_after", busy_log[a0 + 601], 0);
        count_high(a0 + 602, a0 + 649, n);
        check("ur_line_low", n, 0);

        // frame_end in IDLE with empty hold; second frame_end during LATCH ignored
        @(negedge clk);
        frame_end = 1'b1;
        @(negedge clk);
        f         = cyc;
        frame_end = 1'b0;
        wait_until(f + 499);
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        wait_until(f + 1220);
        count_busy(f + 1, f + 1200, n);
        check("fe_busy_latch", n, 1200);
        check("fe_latch_end", busy_log[f + 1201], 0);
        count_busy(f + 1201, f + 1219, n);
        check("fe_not_extended", n, 0);
        count_high(f, f + 1219, n);
        check("fe_no_highs", n, 0);

        // Backpressure: A sending, C held, B waits; order A, C, B
        words[0] = 24'hAAAAAA;
        words[1] = 24'hC3C3C3;
        words[2] = 24'hB00B00;
        stream(3, 1'b1);
        s = acc[0] + 2;
        wait_until(s + 1800 + 1210);
        check("bp_acc_c", acc[1] - acc[0], 2);
        check("bp_acc_b", acc[2] - acc[0], 602);
        count_ready(acc[1], acc[2] - 2, n);
        check("bp_ready_low", n, 0);
        check_pixel("bp_pat_a", s, words[0]);
        check_pixel("bp_pat_c", s + 600, words[1]);
        check_pixel("bp_pat_b", s + 1200, words[2]);

        // Reset mid-pixel with a second pixel held
        send_one(24'hFFFFFF, 1'b0, a0);
        send_one(24'hABCDEF, 1'b0, a1);
        check("rm_hold_loaded", a1 - a0, 2);
        wait_until(a0 + 2 + 180);
        reset = 1'b1;
        @(negedge clk);
        r = cyc;
        check("rm_led", led_sdi, 0);
        check("rm_ready", pixel_ready, 1);
        check("rm_busy", busy, 0);
        check("rm_underrun", underrun, 0);
        reset   = 1'b0;
        base_ur = ur_cnt;
        wait_until(r + 30);
        count_high(r, r + 30, n);
        check("rm_hold_lost", n, 0);
        send_one(24'h5A5A5A, 1'b0, a0);
        wait_until(a0 + 620);
        check("rm_first_high", line_log[a0 + 2], 1);
        check_pixel("rm_pattern", a0 + 2, 24'h5A5A5A);
        check("rm_underrun_time", ur_cyc - a0, 601);
        check("rm_underrun_once", ur_cnt - base_ur, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
